ara_resp_join: RTL and testbench

- Return path of the multi-cluster request distributor.
- Collects the per-cluster accelerator responses produced for each broadcast instruction and buffers them per cluster.
- Issues exactly one merged response to CVA6 once every cluster has answered.
- Sits between the Ara cluster instances and the CVA6 accelerator response port, replacing the "forward cluster 0 only" response path.

---
 rtl/ara_pkg.sv | 57 +++++
 rtl/ara_resp_join_fifo.sv | 70 +++++++
 rtl/ara_resp_join.sv | 134 +++++++++++++
 tb/tb_ara_resp_join.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ara_pkg                                                          |
// | Brief   : Shared types and merge helpers for the Ara response join path.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ara_pkg;

    localparam int unsigned c_max_nr_clusters = 16;
    localparam int unsigned c_elen_width      = 64;
    localparam int unsigned c_trans_id_width  = 3;
    localparam int unsigned c_fflags_width    = 5;

    typedef struct packed {
        logic [c_elen_width-1:0]     result;
        logic [c_trans_id_width-1:0] trans_id;
        logic [c_fflags_width-1:0]   fflags;
        logic                        exc_valid;
        logic [c_elen_width-1:0]     exc_tval;
    } clu_resp_t;

    // Result and id come from cluster 0; flags OR together; tval from the lowest excepting cluster.
    function automatic clu_resp_t merge_resp(input clu_resp_t heads [c_max_nr_clusters],
                                             input int unsigned nr);
        clu_resp_t m;
        logic      found;
        m          = '0;
        found      = 1'b0;
        m.result   = heads[0].result;
        m.trans_id = heads[0].trans_id;
        for (int unsigned i = 0; i < c_max_nr_clusters; i++) begin
            if (i < nr) begin
                m.fflags = m.fflags | heads[i].fflags;
                if (heads[i].exc_valid && !found) begin
                    m.exc_valid = 1'b1;
                    m.exc_tval  = heads[i].exc_tval;
                    found       = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic logic id_mismatch(input clu_resp_t heads [c_max_nr_clusters],
                                         input int unsigned nr);
        logic mm;
        mm = 1'b0;
        for (int unsigned i = 1; i < c_max_nr_clusters; i++) begin
            if ((i < nr) && (heads[i].trans_id != heads[0].trans_id)) begin
                mm = 1'b1;
            end
        end
        return mm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ara_resp_join_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ara_resp_fifo                                                    |
// | Brief   : Synchronous FIFO of clu_resp_t, no fall-through, full/empty.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ara_resp_fifo
    import ara_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  clu_resp_t i_data,
    output clu_resp_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned          c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]     c_full_count = (c_ptr_w + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("ara_resp_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    clu_resp_t          r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_full_count);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; visibility is governed by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ara_resp_join.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ara_resp_join                                                    |
// | Brief   : Buffers per-cluster Ara responses and emits one merged response. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ara_resp_join
    import ara_pkg::*;
#(
    parameter int unsigned NR_CLUSTERS    = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TRANS_ID_WIDTH = 3,
    parameter int unsigned ELEN_WIDTH     = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NR_CLUSTERS-1:0]               clu_resp_valid_i,
    output logic [NR_CLUSTERS-1:0]               clu_resp_ready_o,
    input  logic [NR_CLUSTERS*ELEN_WIDTH-1:0]    clu_result_i,
    input  logic [NR_CLUSTERS*TRANS_ID_WIDTH-1:0] clu_trans_id_i,
    input  logic [NR_CLUSTERS*5-1:0]             clu_fflags_i,
    input  logic [NR_CLUSTERS-1:0]               clu_exc_valid_i,
    input  logic [NR_CLUSTERS*ELEN_WIDTH-1:0]    clu_exc_tval_i,
    input  logic [NR_CLUSTERS-1:0]               clu_store_pending_i,
    output logic                                 resp_valid_o,
    input  logic                                 resp_ready_i,
    output logic [ELEN_WIDTH-1:0]                resp_result_o,
    output logic [TRANS_ID_WIDTH-1:0]            resp_trans_id_o,
    output logic [4:0]                           resp_fflags_o,
    output logic                                 resp_exc_valid_o,
    output logic [ELEN_WIDTH-1:0]                resp_exc_tval_o,
    output logic                                 store_pending_o,
    output logic                                 id_mismatch_o,
    output logic [15:0]                          resp_count_o
);

    if ((NR_CLUSTERS < 1) || (NR_CLUSTERS > c_max_nr_clusters)) begin : g_nr_check
        $error("ara_resp_join: NR_CLUSTERS out of range 1..c_max_nr_clusters");
    end

    if ((TRANS_ID_WIDTH != c_trans_id_width) || (ELEN_WIDTH != c_elen_width)) begin : g_width_check
        $error("ara_resp_join: widths must match the clu_resp_t layout in ara_pkg");
    end

    clu_resp_t              w_push_data [NR_CLUSTERS];
    clu_resp_t              w_head      [NR_CLUSTERS];
    clu_resp_t              w_heads_all [c_max_nr_clusters];
    logic [NR_CLUSTERS-1:0] w_full;
    logic [NR_CLUSTERS-1:0] w_empty;
    logic                   w_join_fire;
    clu_resp_t              w_merged;
    logic                   w_mismatch;

    clu_resp_t              r_resp;
    logic                   r_resp_valid;
    logic                   r_id_mismatch;
    logic [15:0]            r_resp_count;
    logic                   r_store_pending;

    for (genvar c = 0; c < NR_CLUSTERS; c++) begin : g_clu
        assign w_push_data[c] = '{
            result:    clu_result_i[c*ELEN_WIDTH +: ELEN_WIDTH],
            trans_id:  clu_trans_id_i[c*TRANS_ID_WIDTH +: TRANS_ID_WIDTH],
            fflags:    clu_fflags_i[c*5 +: 5],
            exc_valid: clu_exc_valid_i[c],
            exc_tval:  clu_exc_tval_i[c*ELEN_WIDTH +: ELEN_WIDTH]
        };

        ara_resp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_push  (clu_resp_valid_i[c]),
            .i_pop   (w_join_fire),
            .i_data  (w_push_data[c]),
            .o_data  (w_head[c]),
            .o_full  (w_full[c]),
            .o_empty (w_empty[c])
        );
    end

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign clu_resp_ready_o = ~w_full;
    assign w_join_fire      = (&(~w_empty)) && (!r_resp_valid || resp_ready_i);

    always_comb begin
        for (int unsigned i = 0; i < c_max_nr_clusters; i++) begin
            w_heads_all[i] = '0;
        end
        for (int unsigned i = 0; i < NR_CLUSTERS; i++) begin
            w_heads_all[i] = w_head[i];
        end
    end

    assign w_merged   = merge_resp(w_heads_all, NR_CLUSTERS);
    assign w_mismatch = id_mismatch(w_heads_all, NR_CLUSTERS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp          <= '0;
            r_resp_valid    <= 1'b0;
            r_id_mismatch   <= 1'b0;
            r_resp_count    <= '0;
            r_store_pending <= 1'b0;
        end else begin
            if (w_join_fire) begin
                r_resp       <= w_merged;
                r_resp_valid <= 1'b1;
            end else if (resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end
            if (w_join_fire && w_mismatch) begin
                r_id_mismatch <= 1'b1;
            end
            if (r_resp_valid && resp_ready_i) begin
                r_resp_count <= r_resp_count + 16'd1;
            end
            r_store_pending <= |clu_store_pending_i;
        end
    end

    assign resp_valid_o     = r_resp_valid;
    assign resp_result_o    = r_resp.result;
    assign resp_trans_id_o  = r_resp.trans_id;
    assign resp_fflags_o    = r_resp.fflags;
    assign resp_exc_valid_o = r_resp.exc_valid;
    assign resp_exc_tval_o  = r_resp.exc_tval;
    assign store_pending_o  = r_store_pending;
    assign id_mismatch_o    = r_id_mismatch;
    assign resp_count_o     = r_resp_count;

endmodule
`default_nettype wire

// File: tb/tb_ara_resp_join.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ara_resp_join                                                 |
// | Brief   : Directed self-checking bench for ara_resp_join (4 clusters).     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ara_resp_join;

    localparam int NR = 4;

    logic              clk;
    logic              rst_i;
    logic [NR-1:0]     clu_resp_valid_i;
    logic [NR-1:0]     clu_resp_ready_o;
    logic [NR*64-1:0]  clu_result_i;
    logic [NR*3-1:0]   clu_trans_id_i;
    logic [NR*5-1:0]   clu_fflags_i;
    logic [NR-1:0]     clu_exc_valid_i;
    logic [NR*64-1:0]  clu_exc_tval_i;
    logic [NR-1:0]     clu_store_pending_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [63:0]       resp_result_o;
    logic [2:0]        resp_trans_id_o;
    logic [4:0]        resp_fflags_o;
    logic              resp_exc_valid_o;
    logic [63:0]       resp_exc_tval_o;
    logic              store_pending_o;
    logic              id_mismatch_o;
    logic [15:0]       resp_count_o;

    int n_checks = 0;
    int n_pass   = 0;

    ara_resp_join #(
        .NR_CLUSTERS    (NR),
        .FIFO_DEPTH     (4),
        .TRANS_ID_WIDTH (3),
        .ELEN_WIDTH     (64)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .clu_resp_valid_i    (clu_resp_valid_i),
        .clu_resp_ready_o    (clu_resp_ready_o),
        .clu_result_i        (clu_result_i),
        .clu_trans_id_i      (clu_trans_id_i),
        .clu_fflags_i        (clu_fflags_i),
        .clu_exc_valid_i     (clu_exc_valid_i),
        .clu_exc_tval_i      (clu_exc_tval_i),
        .clu_store_pending_i (clu_store_pending_i),
        .resp_valid_o        (resp_valid_o),
        .resp_ready_i        (resp_ready_i),
        .resp_result_o       (resp_result_o),
        .resp_trans_id_o     (resp_trans_id_o),
        .resp_fflags_o       (resp_fflags_o),
        .resp_exc_valid_o    (resp_exc_valid_o),
        .resp_exc_tval_o     (resp_exc_tval_o),
        .store_pending_o     (store_pending_o),
        .id_mismatch_o       (id_mismatch_o),
        .resp_count_o        (resp_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_clu(input int c, input logic [63:0] res, input logic [2:0] id,
                           input logic [4:0] ff, input logic exc, input logic [63:0] tval);
        clu_resp_valid_i[c]         = 1'b1;
        clu_result_i[c*64 +: 64]    = res;
        clu_trans_id_i[c*3 +: 3]    = id;
        clu_fflags_i[c*5 +: 5]      = ff;
        clu_exc_valid_i[c]          = exc;
        clu_exc_tval_i[c*64 +: 64]  = tval;
    endtask

    task automatic clear_valid();
        clu_resp_valid_i = '0;
        clu_fflags_i     = '0;
        clu_exc_valid_i  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        logic seen;
        logic found;
        int   acc;

        rst_i               = 1'b1;
        clu_resp_valid_i    = '0;
        clu_result_i        = '0;
        clu_trans_id_i      = '0;
        clu_fflags_i        = '0;
        clu_exc_valid_i     = '0;
        clu_exc_tval_i      = '0;
        clu_store_pending_i = '0;
        resp_ready_i        = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        check("rst_valid",    resp_valid_o,     0);
        check("rst_ready",    clu_resp_ready_o, 4'hF);
        check("rst_count",    resp_count_o,     0);
        check("rst_mismatch", id_mismatch_o,    0);
        check("rst_store",    store_pending_o,  0);
        check("rst_result",   resp_result_o,    0);
        check("rst_trans_id", resp_trans_id_o,  0);

        // Simultaneous arrival
        set_clu(0, 64'hA, 3'd2, 5'h0, 1'b0, 64'h0);
        set_clu(1, 64'hB, 3'd2, 5'h0, 1'b0, 64'h0);
        set_clu(2, 64'hC, 3'd2, 5'h0, 1'b0, 64'h0);
        set_clu(3, 64'hD, 3'd2, 5'h0, 1'b0, 64'h0);
        tick();
        clear_valid();
        check("sim_n1_valid", resp_valid_o, 0);
        tick();
        check("sim_n2_valid",  resp_valid_o,     1);
        check("sim_result",    resp_result_o,    64'hA);
        check("sim_trans_id",  resp_trans_id_o,  2);
        check("sim_fflags",    resp_fflags_o,    0);
        check("sim_exc_valid", resp_exc_valid_o, 0);
        tick();
        check("sim_count", resp_count_o, 1);
        check("sim_drop",  resp_valid_o, 0);

        // Staggered arrival: current falling edge stands for cycle 5
        seen = 1'b0;
        for (int cyc = 5; cyc <= 22; cyc++) begin
            clear_valid();
            if (cyc == 5) begin
                set_clu(0, 64'h50, 3'd3, 5'h0, 1'b0, 64'h0);
                set_clu(2, 64'h52, 3'd3, 5'h0, 1'b0, 64'h0);
            end
            if (cyc == 8)  set_clu(1, 64'h51, 3'd3, 5'h0, 1'b0, 64'h0);
            if (cyc == 20) set_clu(3, 64'h53, 3'd3, 5'h0, 1'b0, 64'h0);
            if (cyc < 22) begin
                if (resp_valid_o) seen = 1'b1;
                tick();
            end
        end
        check("stag_early",    seen,            0);
        check("stag_valid",    resp_valid_o,    1);
        check("stag_result",   resp_result_o,   64'h50);
        check("stag_trans_id", resp_trans_id_o, 3);
        tick();
        check("stag_count", resp_count_o, 2);

        // Backpressure on cluster 0 only
        resp_ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            set_clu(0, 64'h100 + 64'(k), 3'd1, 5'h0, 1'b0, 64'h0);
            if (clu_resp_ready_o[0]) acc++;
            tick();
        end
        clear_valid();
        check("bp_accepted", acc,              4);
        check("bp_ready",    clu_resp_ready_o, 4'b1110);
        check("bp_valid",    resp_valid_o,     0);
        check("bp_count",    resp_count_o,     2);
        do_reset();
        resp_ready_i = 1'b1;
        check("bp_rst_ready", clu_resp_ready_o, 4'hF);

        // Merge rules, with the output held under backpressure
        resp_ready_i = 1'b0;
        set_clu(0, 64'h77, 3'd1, 5'h00, 1'b0, 64'h0);
        set_clu(1, 64'h78, 3'd1, 5'h01, 1'b1, 64'h1000);
        set_clu(2, 64'h79, 3'd1, 5'h00, 1'b0, 64'h0);
        set_clu(3, 64'h7A, 3'd1, 5'h10, 1'b1, 64'h3000);
        tick();
        clear_valid();
        tick();
        check("merge_valid",     resp_valid_o,     1);
        check("merge_result",    resp_result_o,    64'h77);
        check("merge_fflags",    resp_fflags_o,    5'h11);
        check("merge_exc_valid", resp_exc_valid_o, 1);
        check("merge_exc_tval",  resp_exc_tval_o,  64'h1000);
        tick();
        check("hold_valid", resp_valid_o,    1);
        check("hold_tval",  resp_exc_tval_o, 64'h1000);
        check("hold_count", resp_count_o,    0);
        resp_ready_i = 1'b1;
        tick();
        check("hold_release", resp_valid_o, 0);
        check("hold_count1",  resp_count_o, 1);

        // Transaction id mismatch
        set_clu(0, 64'h40, 3'd4, 5'h0, 1'b0, 64'h0);
        set_clu(1, 64'h41, 3'd4, 5'h0, 1'b0, 64'h0);
        set_clu(2, 64'h42, 3'd5, 5'h0, 1'b0, 64'h0);
        set_clu(3, 64'h43, 3'd4, 5'h0, 1'b0, 64'h0);
        tick();
        clear_valid();
        check("mm_before", id_mismatch_o, 0);
        tick();
        check("mm_valid",    resp_valid_o,    1);
        check("mm_trans_id", resp_trans_id_o, 4);
        check("mm_flag",     id_mismatch_o,   1);

        // Store-pending is a registered OR
        clu_store_pending_i = 4'b0100;
        tick();
        check("sp_set", store_pending_o, 1);
        clu_store_pending_i = 4'b0000;
        tick();
        check("sp_clr", store_pending_o, 0);

        // Stream at full throughput until the counter wraps
        for (int c = 0; c < NR; c++) set_clu(c, 64'h600 + 64'(c), 3'd4, 5'h0, 1'b0, 64'h0);
        found = 1'b0;
        for (int k = 0; k < 70000 && !found; k++) begin
            tick();
            if (resp_count_o == 16'hFFFF) found = 1'b1;
        end
        check("wrap_reach_ffff", found,        1);
        check("wrap_valid",      resp_valid_o, 1);
        tick();
        check("wrap_zero", resp_count_o, 0);
        clear_valid();
        repeat (8) tick();
        check("wrap_drained", resp_valid_o,  0);
        check("mm_sticky",    id_mismatch_o, 1);

        // Reset with three clusters buffered
        set_clu(0, 64'h90, 3'd6, 5'h0, 1'b0, 64'h0);
        set_clu(1, 64'h91, 3'd6, 5'h0, 1'b0, 64'h0);
        set_clu(2, 64'h92, 3'd6, 5'h0, 1'b0, 64'h0);
        tick();
        clear_valid();
        tick();
        check("mid_no_out", resp_valid_o, 0);
        do_reset();
        check("mid_valid",    resp_valid_o,     0);
        check("mid_ready",    clu_resp_ready_o, 4'hF);
        check("mid_count",    resp_count_o,     0);
        check("mid_mismatch", id_mismatch_o,    0);
        check("mid_result",   resp_result_o,    0);
        check("mid_tval",     resp_exc_tval_o,  0);
        set_clu(3, 64'h93, 3'd6, 5'h0, 1'b0, 64'h0);
        tick();
        clear_valid();
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (resp_valid_o) seen = 1'b1;
        end
        check("mid_no_partial", seen,         0);
        check("mid_count_end",  resp_count_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
